// File: rtl/sram_like_ram_slave_pkg.sv
// sram_like_ram_slave_pkg: bus size encodings and response entry layout
package sram_like_ram_slave_pkg;
  localparam logic [1:0] SRAM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] SRAM_SIZE_HALF = 2'd1;
  localparam logic [1:0] SRAM_SIZE_WORD = 2'd2;
  localparam int SRAM_RSP_WD = 37;
  typedef struct packed {
    logic is_write;
    logic [31:0] data;
    logic [3:0] timer;
  } rsp_t;
  function automatic logic [3:0] tick(input logic [3:0] t);
    return t == 4'd0 ? 4'd0 : t - 4'd1;
  endfunction
endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: synchronous FIFO with count that exposes every entry so its owner can age them
module sram_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 37
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              din,
  input  logic [DEPTH-1:0][W-1:0]   upd,
  output logic [DEPTH-1:0][W-1:0]   ents,
  output logic [W-1:0]              head,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] rp, wp;
  assign head = ents[rp];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      ents  <= '0;
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else begin
      ents <= upd;
      if (push) ents[wp] <= din;
      wp    <= wp + PW'(push);
      rp    <= rp + PW'(pop);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
endmodule

// File: rtl/sram_like_ram_slave.sv
// sram_like_ram_slave: SRAM-like bus responder with word RAM and fixed-latency in-order responses
module sram_like_ram_slave
  import sram_like_ram_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DELAY = 1,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic [CW-1:0] count;
  logic acc;
  logic unused_in;
  rsp_t din, head;
  rsp_t [DEPTH-1:0] ents, upd;
  assign idx = addr[ADDR_WIDTH+1:2];
  assign unused_in = ^{size, addr[31:ADDR_WIDTH+2], addr[1:0]} ^ (size inside {SRAM_SIZE_BYTE, SRAM_SIZE_HALF, SRAM_SIZE_WORD});
  assign addr_ok = count < CW'(DEPTH);
  assign acc = req && addr_ok;
  assign data_ok = count != '0 && head.timer == 4'd0;
  assign rdata = data_ok && !head.is_write ? head.data : 32'd0;
  assign din = '{is_write: wr, data: wr ? 32'd0 : mem[idx], timer: 4'(DELAY - 1)};
  for (genvar g = 0; g < DEPTH; g++) begin : g_age
    assign upd[g] = '{is_write: ents[g].is_write, data: ents[g].data, timer: tick(ents[g].timer)};
  end
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (acc && wr && wstrb[i]) mem[idx][8*i+:8] <= wdata[8*i+:8];
  sram_rsp_fifo #(.DEPTH(DEPTH), .W(SRAM_RSP_WD)) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .push(acc),
    .pop(data_ok),
    .din(din),
    .upd(upd),
    .ents(ents),
    .head(head),
    .count(count)
  );
endmodule

// File: tb/tb_sram_like_ram_slave.sv
// tb_sram_like_ram_slave: scoreboard bench over three latency configurations
module tb_sram_like_ram_slave;
  typedef struct {
    int due;
    logic [31:0] data;
  } exp_t;
  logic clk = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit done [3];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int k);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc%0d got %h want %h", name, k, cyc, act, exp);
    end
  endtask
  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int D = k == 0 ? 1 : k == 1 ? 8 : 3;
    logic resetn = 0;
    logic req = 0;
    logic wr = 0;
    logic [3:0] wstrb = 0;
    logic [31:0] addr = 0;
    logic [31:0] wdata = 0;
    logic addr_ok, data_ok;
    logic [31:0] rdata;
    exp_t q [$];
    exp_t e;
    int last_due = 0;
    sram_like_ram_slave #(.ADDR_WIDTH(14), .DELAY(D), .DEPTH(4)) dut (
      .clk(clk),
      .resetn(resetn),
      .req(req),
      .wr(wr),
      .size(2'd2),
      .wstrb(wstrb),
      .addr(addr),
      .wdata(wdata),
      .addr_ok(addr_ok),
      .data_ok(data_ok),
      .rdata(rdata)
    );
    always @(negedge clk) begin
      if (!resetn) begin
        chk("rst_addr_ok", 32'(addr_ok), 32'd1, k);
        chk("rst_data_ok", 32'(data_ok), 32'd0, k);
        chk("rst_rdata", rdata, 32'd0, k);
      end else if (data_ok) begin
        if (q.size() == 0) chk("spurious_data_ok", 32'(data_ok), 32'd0, k);
        else begin
          e = q.pop_front();
          chk("rsp_cycle", 32'(cyc), 32'(e.due), k);
          chk("rdata", rdata, e.data, k);
        end
      end else begin
        chk("idle_rdata", rdata, 32'd0, k);
        if (q.size() != 0 && q[0].due <= cyc) begin
          void'(q.pop_front());
          chk("missing_data_ok", 32'(data_ok), 32'd1, k);
        end
      end
    end
    task automatic step();
      @(posedge clk);
      #1;
    endtask
    task automatic idle(input int n);
      req = 0;
      repeat (n) begin
        chk("idle_addr_ok", 32'(addr_ok), 32'(q.size() < 4), k);
        step();
      end
    endtask
    task automatic op(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input logic [31:0] x);
      bit ok;
      int c;
      req = 1;
      wr = w;
      addr = a;
      wstrb = s;
      wdata = d;
      for (int n = 0; n < 64; n++) begin
        ok = q.size() < 4;
        chk("addr_ok", 32'(addr_ok), 32'(ok), k);
        step();
        if (ok) begin
          c = cyc - 1;
          last_due = (c + D > last_due) ? c + D : last_due + 1;
          q.push_back('{due: last_due, data: w ? 32'd0 : x});
          req = 0;
          return;
        end
      end
      chk("accept_timeout", 32'(addr_ok), 32'd1, k);
      req = 0;
    endtask
    task automatic do_reset(input int n);
      req = 0;
      resetn = 0;
      q.delete();
      last_due = 0;
      repeat (n) step();
      resetn = 1;
    endtask
    initial begin
      repeat (3) step();
      resetn = 1;
      idle(3);
      op(1, 32'h10, 4'hF, 32'hDEADBEEF, 0);
      op(0, 32'h10, 4'h0, 0, 32'hDEADBEEF);
      op(1, 32'h20, 4'hF, 32'h11223344, 0);
      op(1, 32'h20, 4'h2, 32'h0000AA00, 0);
      op(0, 32'h20, 4'h0, 0, 32'h1122AA44);
      op(1, 32'h10, 4'h0, 32'h12345678, 0);
      op(0, 32'h8000_0012, 4'h0, 0, 32'hDEADBEEF);
      op(1, 32'hFFFC, 4'hF, 32'h55555555, 0);
      op(1, 32'hFFFC, 4'h9, 32'hA1B2C3D4, 0);
      op(0, 32'hFFFC, 4'h0, 0, 32'hA15555D4);
      op(0, 32'h10, 4'h0, 0, 32'hDEADBEEF);
      idle(2);
      for (int i = 0; i < 16; i++) op(1, 32'(i * 4), 4'hF, 32'hC0DE0000 + 32'(i * 32'h111), 0);
      idle(20);
      for (int i = 0; i < 16; i++) op(0, 32'(i * 4), 4'h0, 0, 32'hC0DE0000 + 32'(i * 32'h111));
      idle(20);
      op(0, 32'h0, 4'h0, 0, 32'hC0DE0000);
      op(0, 32'h4, 4'h0, 0, 32'hC0DE0111);
      op(0, 32'h8, 4'h0, 0, 32'hC0DE0222);
      do_reset(1);
      op(0, 32'h3C, 4'h0, 0, 32'hC0DE0FFF);
      idle(30);
      chk("drain", 32'(q.size()), 32'd0, k);
      done[k] = 1;
    end
  end
  initial begin
    fork
      wait (done[0] && done[1] && done[2]);
      #100000;
    join_any
    chk("all_done", 32'(done[0] && done[1] && done[2]), 32'd1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
